uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of byte requesters sharing one UART transmitter, 1..8.
REQ-002 Parameter DATA_W, default 8: byte width; matches 8 data bits per frame.
REQ-003 Parameter TIMEOUT, default 4096: max clk cycles allowed from tx_start to tx_done.
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req  in  NREQ  per-requester "byte pending"; held high until acked.
REQ-007 req_data  in  NREQ*DATA_W  requester i byte at bits [i*DATA_W +: DATA_W]; stable while req[i] high.
REQ-008 ack  out  NREQ  one-cycle pulse; byte of requester i accepted.
REQ-009 tx_start  out  1  one-cycle pulse to UART TX: start frame with tx_data.
REQ-010 tx_data  out  DATA_W  registered byte for UART TX; stable from tx_start until tx_done.
REQ-011 tx_busy  in  1  UART TX frame in progress.
REQ-012 tx_done  in  1  one-cycle pulse from UART TX after stop bit.
REQ-013 grant_id  out  ceil(log2(NREQ)), min 1  index of the current or last granted requester.
REQ-014 active  out  1  high in any state other than IDLE.
REQ-015 err  out  1  sticky timeout flag.
REQ-016 err_clr  in  1  clears err.

Function
REQ-017 FSM states: IDLE, START, WAIT; encoding is implementation choice.
REQ-018 IDLE -> START when any req bit is high and tx_busy is low; otherwise remain in IDLE.
REQ-019 Selection on that edge: first set req bit searching upward from rr_ptr, wrapping NREQ-1 -> 0.
REQ-020 On the IDLE->START edge: latch the selected byte into tx_data, the index into grant_id, and set ack[sel] for the following cycle only.
REQ-021 START lasts exactly one cycle: tx_start=1, ack[grant_id]=1; next state WAIT.
REQ-022 Latency: req sampled high at edge k in IDLE -> ack and tx_start high during cycle k..k+1; both low afterwards.
REQ-023 WAIT: on tx_done=1 -> IDLE; rr_ptr <= (grant_id+1) mod NREQ.
REQ-024 WAIT: timeout counter counts cycles; at TIMEOUT without tx_done -> IDLE, err<=1, rr_ptr advanced as in REQ-023.
REQ-025 tx_done outside WAIT is ignored; tx_busy is sampled only in IDLE.
REQ-026 At most one ack bit high in any cycle; ack and tx_start always coincide.
REQ-027 Requester still holding req after ack is treated as a new byte, eligible only after the others in round-robin order.
REQ-028 req[i] dropped before grant is never served; no ack is issued for it.
REQ-029 Min spacing: tx_done in cycle m -> earliest next tx_start in cycle m+2.
REQ-030 err_clr=1 clears err next edge; simultaneous timeout and err_clr -> err=1 (set wins).
REQ-031 NREQ=1: grant_id constant 0; behaviour otherwise identical.

Reset
REQ-032 rst=1 at edge: state=IDLE, rr_ptr=0, grant_id=0, tx_data=0, ack=0, tx_start=0, active=0, err=0, timeout counter=0.
REQ-033 Reset mid-frame (START or WAIT): no ack or tx_start after the reset edge; pending req served fresh after rst drops, starting from index 0.
REQ-034 All outputs registered; no output depends combinationally on inputs.

Verification
REQ-035 Single: req=0001, data0=0xA5, tx_done 160 cycles after tx_start -> ack=0001 and tx_start for 1 cycle, tx_data=0xA5, grant_id=0, active low the cycle after tx_done+1.
REQ-036 All four req held continuously, data i=0x10+i -> tx_data sequence 0x10,0x11,0x12,0x13,0x10..., ack one-hot each time.
REQ-037 rr_ptr=2 (after serving 1), req=1001 -> requester 3 granted before 0.
REQ-038 req=0010 with tx_busy=1 for 20 cycles -> no grant until tx_busy low, then grant within one cycle.
REQ-039 TIMEOUT=16, no tx_done -> after 16 WAIT cycles return to IDLE, err=1; err_clr pulse -> err=0.
REQ-040 rst asserted during WAIT with req=1111 -> outputs at reset values; after release first grant is requester 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte requesters.
// A grant registers byte and index, pulses ack+tx_start for one cycle, then waits for tx_done or a timeout.
module uart_tx_arbiter #(
  parameter  int NREQ    = 4,
  parameter  int DATA_W  = 8,
  parameter  int TIMEOUT = 4096,
  localparam int GW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NREQ-1:0]        i_req,
  input  logic [NREQ*DATA_W-1:0] i_req_data,
  output logic [NREQ-1:0]        o_ack,
  output logic                   o_tx_start,
  output logic [DATA_W-1:0]      o_tx_data,
  input  logic                   i_tx_busy,
  input  logic                   i_tx_done,
  output logic [GW-1:0]          o_grant_id,
  output logic                   o_active,
  output logic                   o_err,
  input  logic                   i_err_clr
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
  localparam logic [GW:0]   NREQ_W   = (GW+1)'(NREQ);
  localparam logic [GW-1:0] LAST_ID  = GW'(NREQ - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_START = 2'd1, S_WAIT = 2'd2} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [GW-1:0]       r_rr_ptr;
  logic [GW-1:0]       r_grant_id;
  logic [DATA_W-1:0]   r_tx_data;
  logic [CW-1:0]       r_tmo_cnt;
  logic                r_err;

  logic                w_found;
  logic [GW-1:0]       w_sel;
  logic [GW:0]         w_cand_sum;
  logic [GW-1:0]       w_cand;
  logic [DATA_W-1:0]   w_sel_data;
  logic                w_grant;
  logic                w_wait_end;
  logic                w_timeout;

  // First pending requester at or above rr_ptr, wrapping at NREQ.
  always_comb begin
    w_found    = 1'b0;
    w_sel      = '0;
    w_cand_sum = '0;
    w_cand     = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_cand_sum = {1'b0, r_rr_ptr} + (GW+1)'(i);
      if (w_cand_sum >= NREQ_W) begin
        w_cand_sum = w_cand_sum - NREQ_W;
      end
      w_cand = w_cand_sum[GW-1:0];
      if (!w_found && i_req[w_cand]) begin
        w_found = 1'b1;
        w_sel   = w_cand;
      end
    end
  end

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_sel == GW'(i)) begin
        w_sel_data = i_req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_wait_end  = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found && !i_tx_busy) begin
          w_state_nxt = S_START;
          w_grant     = 1'b1;
        end
      end
      S_START: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (i_tx_done) begin
          w_state_nxt = S_IDLE;
          w_wait_end  = 1'b1;
        end else if (r_tmo_cnt == TMO_LAST) begin
          w_state_nxt = S_IDLE;
          w_wait_end  = 1'b1;
          w_timeout   = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_tx_data  <= '0;
      r_tmo_cnt  <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_grant) begin
        r_grant_id <= w_sel;
        r_tx_data  <= w_sel_data;
      end
      if (w_wait_end) begin
        r_rr_ptr <= (r_grant_id == LAST_ID) ? '0 : r_grant_id + 1'b1;
      end
      if (r_state == S_WAIT && !w_wait_end) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end else begin
        r_tmo_cnt <= '0;
      end
      // A timeout on the same edge as err_clr keeps the flag set.
      if (w_timeout) begin
        r_err <= 1'b1;
      end else if (i_err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  always_comb begin
    o_tx_start = (r_state == S_START);
    o_active   = (r_state != S_IDLE);
    o_ack      = '0;
    if (r_state == S_START) begin
      o_ack[r_grant_id] = 1'b1;
    end
  end

  assign o_tx_data  = r_tx_data;
  assign o_grant_id = r_grant_id;
  assign o_err      = r_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized round-robin traffic checked against a queue-free reference.
// A second instance with a short timeout exercises the error path.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic        tx_busy;
  logic        tx_done;
  logic        err_clr;
  logic        tx_done2;
  logic [3:0]  ack, ack2;
  logic        tx_start, tx_start2;
  logic [7:0]  tx_data, tx_data2;
  logic [1:0]  grant_id, grant_id2;
  logic        active, active2;
  logic        err, err2;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] data [4];
  int         m_rr;

  uart_tx_arbiter #(.NREQ(4), .DATA_W(8), .TIMEOUT(4096)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_req_data(req_data),
    .o_ack(ack), .o_tx_start(tx_start), .o_tx_data(tx_data),
    .i_tx_busy(tx_busy), .i_tx_done(tx_done), .o_grant_id(grant_id),
    .o_active(active), .o_err(err), .i_err_clr(err_clr)
  );

  uart_tx_arbiter #(.NREQ(4), .DATA_W(8), .TIMEOUT(16)) dut_tmo (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_req_data(req_data),
    .o_ack(ack2), .o_tx_start(tx_start2), .o_tx_data(tx_data2),
    .i_tx_busy(tx_busy), .i_tx_done(tx_done2), .o_grant_id(grant_id2),
    .o_active(active2), .o_err(err2), .i_err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pick(input logic [3:0] r, input int ptr);
    for (int k = 0; k < 4; k++) begin
      if (r[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  task automatic set_data(input int i, input logic [7:0] v);
    data[i] = v;
    req_data[i*8 +: 8] = v;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; tx_done = 1'b0; tx_busy = 1'b0; err_clr = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_rr = 0;
  endtask

  task automatic wait_start(input int budget, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      if (tx_start === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; req_data = 32'h13121110;
    tx_done = 1'b0; tx_busy = 1'b0; err_clr = 1'b0; tx_done2 = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack: got %b want 0000", ack); end
    n_checks++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
    n_checks++; if (active !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b want 0", active); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
    n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    rst = 1'b0; req = '0;
  endtask

  task automatic test_single();
    bit seen;
    bit bad;
    do_reset();
    set_data(0, 8'hA5);
    req = 4'b0001;
    wait_start(1, seen);
    n_checks++; if (!seen) begin n_fail++; $display("FAIL single_start: tx_start not seen within 1 cycle"); end
    n_checks++; if (ack !== 4'b0001) begin n_fail++; $display("FAIL single_ack: got %b want 0001", ack); end
    n_checks++; if (tx_data !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h want a5", tx_data); end
    n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL single_grant: got %0d want 0", grant_id); end
    req = 4'b0000;
    @(negedge clk);
    n_checks++; if (tx_start !== 1'b0 || ack !== 4'b0000) begin n_fail++; $display("FAIL single_pulse_len: tx_start %b ack %b want 0 0000", tx_start, ack); end
    bad = 1'b0;
    for (int c = 0; c < 158; c++) begin
      @(negedge clk);
      if (active !== 1'b1 || tx_data !== 8'hA5 || tx_start !== 1'b0) bad = 1'b1;
    end
    n_checks++; if (bad) begin n_fail++; $display("FAIL single_hold: active/tx_data not stable during frame (active %b data %h)", active, tx_data); end
    pulse_done();
    n_checks++; if (active !== 1'b0) begin n_fail++; $display("FAIL single_idle: active %b want 0", active); end
  endtask

  task automatic test_round_robin();
    bit seen;
    int exp;
    do_reset();
    for (int i = 0; i < 4; i++) set_data(i, 8'h10 + 8'(i));
    req = 4'b1111;
    for (int f = 0; f < 6; f++) begin
      wait_start(2, seen);
      exp = pick(req, m_rr);
      n_checks++; if (!seen) begin n_fail++; $display("FAIL rr_start: frame %0d no tx_start", f); end
      n_checks++; if (tx_data !== 8'h10 + 8'(f % 4)) begin n_fail++; $display("FAIL rr_data: frame %0d got %h want %h", f, tx_data, 8'h10 + 8'(f % 4)); end
      n_checks++; if (ack !== 4'(1 << exp)) begin n_fail++; $display("FAIL rr_ack: frame %0d got %b want %b", f, ack, 4'(1 << exp)); end
      repeat (3) @(negedge clk);
      pulse_done();
      m_rr = (exp + 1) % 4;
    end
  endtask

  task automatic test_rr_pointer();
    bit seen;
    do_reset();
    set_data(1, 8'h21);
    req = 4'b0010;
    wait_start(1, seen);
    n_checks++; if (!seen || grant_id !== 2'd1) begin n_fail++; $display("FAIL ptr_first: seen %b grant %0d want 1", seen, grant_id); end
    req = 4'b0000;
    repeat (2) @(negedge clk);
    set_data(0, 8'h30);
    set_data(3, 8'h33);
    pulse_done();
    req = 4'b1001;
    wait_start(1, seen);
    n_checks++; if (!seen || grant_id !== 2'd3 || tx_data !== 8'h33) begin n_fail++; $display("FAIL ptr_wrap_3: grant %0d data %h want 3 33", grant_id, tx_data); end
    req = 4'b0001;
    repeat (2) @(negedge clk);
    pulse_done();
    wait_start(1, seen);
    n_checks++; if (!seen || grant_id !== 2'd0 || tx_data !== 8'h30) begin n_fail++; $display("FAIL ptr_wrap_0: grant %0d data %h want 0 30", grant_id, tx_data); end
    req = 4'b0000;
    repeat (2) @(negedge clk);
    pulse_done();
  endtask

  task automatic test_busy();
    bit seen;
    bit early;
    tx_busy = 1'b1;
    set_data(1, 8'h5C);
    req = 4'b0010;
    early = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (tx_start !== 1'b0 || active !== 1'b0) early = 1'b1;
    end
    n_checks++; if (early) begin n_fail++; $display("FAIL busy_hold: grant issued while tx_busy high"); end
    tx_busy = 1'b0;
    wait_start(1, seen);
    n_checks++; if (!seen || ack !== 4'b0010 || tx_data !== 8'h5C) begin n_fail++; $display("FAIL busy_release: seen %b ack %b data %h want 1 0010 5c", seen, ack, tx_data); end
    req = 4'b0000;
    @(negedge clk);
    pulse_done();
  endtask

  task automatic test_timeout();
    bit seen;
    do_reset();
    set_data(2, 8'h77);
    req = 4'b0100;
    seen = 1'b0;
    for (int c = 0; c < 4 && !seen; c++) begin
      @(negedge clk);
      if (tx_start2 === 1'b1) seen = 1'b1;
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL tmo_start: no tx_start on timeout instance"); end
    req = 4'b0000;
    repeat (16) @(negedge clk);
    n_checks++; if (active2 !== 1'b1 || err2 !== 1'b0) begin n_fail++; $display("FAIL tmo_wait16: active %b err %b want 1 0", active2, err2); end
    @(negedge clk);
    n_checks++; if (active2 !== 1'b0 || err2 !== 1'b1) begin n_fail++; $display("FAIL tmo_fire: active %b err %b want 0 1", active2, err2); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_checks++; if (err2 !== 1'b0) begin n_fail++; $display("FAIL tmo_clr: err %b want 0", err2); end
    req = 4'b0100;
    seen = 1'b0;
    for (int c = 0; c < 4 && !seen; c++) begin
      @(negedge clk);
      if (tx_start2 === 1'b1) seen = 1'b1;
    end
    req = 4'b0000;
    repeat (15) @(negedge clk);
    err_clr = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (!seen || err2 !== 1'b1) begin n_fail++; $display("FAIL tmo_set_wins: seen %b err %b want 1 1", seen, err2); end
    @(negedge clk);
    err_clr = 1'b0;
    n_checks++; if (err2 !== 1'b0) begin n_fail++; $display("FAIL tmo_clr2: err %b want 0", err2); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    do_reset();
    for (int i = 0; i < 4; i++) set_data(i, 8'h10 + 8'(i));
    req = 4'b1111;
    wait_start(1, seen);
    repeat (2) @(negedge clk);
    pulse_done();
    wait_start(1, seen);
    n_checks++; if (!seen || grant_id !== 2'd1) begin n_fail++; $display("FAIL mid_setup: seen %b grant %0d want 1 1", seen, grant_id); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (ack !== 4'b0 || tx_start !== 1'b0 || active !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ctl: ack %b start %b active %b want 0000 0 0", ack, tx_start, active); end
    n_checks++; if (tx_data !== 8'h00 || grant_id !== 2'd0) begin n_fail++; $display("FAIL mid_reset_dat: data %h grant %0d want 00 0", tx_data, grant_id); end
    rst = 1'b0;
    wait_start(1, seen);
    n_checks++; if (!seen || grant_id !== 2'd0 || tx_data !== 8'h10) begin n_fail++; $display("FAIL mid_after: seen %b grant %0d data %h want 1 0 10", seen, grant_id, tx_data); end
  endtask

  task automatic test_random();
    bit         seen;
    int         exp;
    int         other;
    logic [3:0] nr;
    do_reset();
    for (int f = 0; f < 40; f++) begin
      if (req == 4'b0000) begin
        nr = 4'($urandom_range(1, 15));
        for (int i = 0; i < 4; i++) if (nr[i]) set_data(i, 8'($urandom));
        req = nr;
      end
      wait_start(1, seen);
      exp = pick(req, m_rr);
      n_checks++; if (!seen) begin n_fail++; $display("FAIL rand_start: frame %0d req %b no tx_start", f, req); end
      n_checks++; if (grant_id !== 2'(exp)) begin n_fail++; $display("FAIL rand_grant: frame %0d got %0d want %0d", f, grant_id, exp); end
      n_checks++; if (ack !== 4'(1 << exp)) begin n_fail++; $display("FAIL rand_ack: frame %0d got %b want %b", f, ack, 4'(1 << exp)); end
      n_checks++; if (tx_data !== data[exp]) begin n_fail++; $display("FAIL rand_data: frame %0d got %h want %h", f, tx_data, data[exp]); end
      other = $urandom_range(0, 3);
      case ($urandom_range(0, 3))
        0: req[exp] = 1'b0;
        1: ;
        2: begin req[exp] = 1'b0; req[other] = 1'b0; end
        default: begin
          req[exp] = 1'b0;
          if (!req[other] && other != exp) begin set_data(other, 8'($urandom)); req[other] = 1'b1; end
        end
      endcase
      repeat ($urandom_range(1, 12)) @(negedge clk);
      pulse_done();
      m_rr = (exp + 1) % 4;
      n_checks++; if (tx_start !== 1'b0 || active !== 1'b0) begin n_fail++; $display("FAIL rand_spacing: frame %0d start %b active %b want 0 0", f, tx_start, active); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_rr_pointer();
    test_busy();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
